spi_bus_ctrl: RTL and testbench
===============================

SPI_BUS_CTRL -- requirements
Module: spi_bus_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles bus_req waits for bus_ack.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port cs_n  input  1  SPI chip select (high = frame ended).
REQ-005 The block SHALL have port address_ready  input  1  one-cycle pulse; addr and status are valid.
REQ-006 The block SHALL have port data_ready  input  1  one-cycle pulse; wdata is valid on writes, or the read word has been consumed on reads.
REQ-007 The block SHALL have ports addr  input  20, status  input  4 (command code) and wdata  input  16, all from the SPI data path.
REQ-008 The block SHALL have ports rdata  output  16 (read word to data path) and rdata_valid  output  1.
REQ-009 The block SHALL have ports bus_req  output  1, bus_we  output  1, bus_addr  output  20 and bus_wdata  output  16.
REQ-010 The block SHALL have ports bus_ack  input  1 and bus_rdata  input  16.
REQ-011 The block SHALL have ports busy  output  1 (state is not IDLE) and err  output  1 (one-cycle error pulse).

Function
REQ-012 Commands SHALL be: 4'h2 single write, 4'h3 burst write, 4'h8 single read, 4'h9 burst read; any other code is illegal.
REQ-013 The FSM SHALL have the states IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_HOLD, DRAIN.
REQ-014 In IDLE, address_ready with a write command SHALL latch addr and enter WR_WAIT; with a read command it SHALL latch addr and enter RD_BUS.
REQ-015 In IDLE, address_ready with an illegal command SHALL pulse err the next cycle and stay in IDLE.
REQ-016 In WR_WAIT, data_ready SHALL latch wdata into bus_wdata and enter WR_BUS.
REQ-017 In WR_BUS and RD_BUS, bus_req SHALL be high with bus_addr, bus_we and bus_wdata held stable until bus_ack is sampled high.
REQ-018 bus_req SHALL rise the cycle after the state is entered and SHALL fall the cycle after bus_ack; exactly one access occurs per ack.
REQ-019 On ack in RD_BUS, rdata SHALL take bus_rdata and rdata_valid SHALL go high the next cycle, and the FSM SHALL enter RD_HOLD.
REQ-020 On ack in WR_BUS, a single write SHALL return to IDLE; a burst write SHALL increment the address and return to WR_WAIT.
REQ-021 In RD_HOLD, data_ready SHALL clear rdata_valid; a burst read then increments the address and enters RD_BUS; a single read returns to IDLE.
REQ-022 The address increment SHALL be modulo 2^20 (20'hFFFFF -> 20'h00000).
REQ-023 If bus_ack is absent for TIMEOUT cycles of bus_req, the block SHALL drop bus_req, pulse err and return to IDLE; a timed-out read SHALL load rdata = 16'hFFFF with rdata_valid high.
REQ-024 cs_n high in WR_WAIT or RD_HOLD SHALL force IDLE the next cycle and clear rdata_valid.
REQ-025 cs_n high in WR_BUS or RD_BUS SHALL enter DRAIN, which holds bus_req until ack or timeout and then goes to IDLE; no further access is issued.
REQ-026 data_ready in WR_BUS (overrun) or address_ready outside IDLE SHALL be ignored and SHALL pulse err.
REQ-027 Latency: a read address_ready at cycle N SHALL give bus_req high at N+1; an ack at cycle M SHALL give rdata_valid at M+1.

Reset
REQ-028 While reset_n is low at a clock edge, the state SHALL become IDLE, and rdata, rdata_valid, bus_req, bus_we, bus_addr, bus_wdata, busy and err SHALL all become 0.
REQ-029 Reset mid-transaction SHALL abandon the access immediately; bus_req is low on the cycle after the reset edge.

Structure
REQ-030 The command codes, the state encoding and the default TIMEOUT SHALL live in the shared package spi_pkg.
REQ-031 The timeout counter SHALL be the sub-module spi_bus_timer (inputs: start, clear; output: expired).

Verification
REQ-032 Single write: cmd 4'h2, addr 20'h00010, wdata 16'hC69A, ack after 3 cycles -> exactly one bus_we=1 access at 20'h00010 with data 16'hC69A, then IDLE.
REQ-033 Burst read: cmd 4'h9, addr 20'hFFFFF, three data_ready pulses -> accesses at 20'hFFFFF, 20'h00000 and 20'h00001, with rdata matching bus_rdata each time.
REQ-034 Timeout: a read with bus_ack tied low -> bus_req high for exactly 255 cycles, then err pulse, rdata = 16'hFFFF and IDLE.
REQ-035 cs_n rises during WR_BUS with ack at +5 -> bus_req is held until ack, no second access occurs, and the FSM returns to IDLE.
REQ-036 Illegal cmd 4'h5 -> err pulses for one cycle and bus_req never rises; reset_n low mid-RD_BUS -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-bus bridge: command codes, FSM encoding,
// default access timeout and small command-decode helpers.
package spi_pkg;

    localparam logic [3:0] CMD_WR_SINGLE = 4'h2;
    localparam logic [3:0] CMD_WR_BURST  = 4'h3;
    localparam logic [3:0] CMD_RD_SINGLE = 4'h8;
    localparam logic [3:0] CMD_RD_BURST  = 4'h9;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_WAIT = 3'd1,
        ST_WR_BUS  = 3'd2,
        ST_RD_BUS  = 3'd3,
        ST_RD_HOLD = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    function automatic logic cmd_is_write(input logic [3:0] cmd);
        return (cmd == CMD_WR_SINGLE) || (cmd == CMD_WR_BURST);
    endfunction

    function automatic logic cmd_is_read(input logic [3:0] cmd);
        return (cmd == CMD_RD_SINGLE) || (cmd == CMD_RD_BURST);
    endfunction

    function automatic logic cmd_is_burst(input logic [3:0] cmd);
        return (cmd == CMD_WR_BURST) || (cmd == CMD_RD_BURST);
    endfunction

endpackage

// File: rtl/spi_bus_timer.sv
// Access watchdog: counts cycles while start is high and flags the last
// permitted cycle so the controller can abandon the access on that edge.
module spi_bus_timer
    import spi_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: restart when idle, otherwise advance up to the last cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (start && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = start && !clear && (count_q == LAST);

endmodule

// File: rtl/spi_bus_ctrl.sv
// Bridges decoded SPI commands onto a simple req/ack bus: single and burst
// reads/writes, frame-abort handling and a bounded wait for bus_ack.
module spi_bus_ctrl
    import spi_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_n,
    input  logic        address_ready,
    input  logic        data_ready,
    input  logic [19:0] addr,
    input  logic [3:0]  status,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [19:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        busy,
    output logic        err
);

    state_t      state_q, state_d;
    logic        burst_q, burst_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [19:0] bus_addr_q, bus_addr_d;
    logic [15:0] bus_wdata_q, bus_wdata_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        timer_expired;

    spi_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bus_req_q),
        .clear   (!bus_req_q),
        .expired (timer_expired)
    );

    // Next-state and output decode; bus_req and busy follow the next state so
    // they change on the same edge as the state register.
    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        err_d         = address_ready && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (address_ready) begin
                    rdata_valid_d = 1'b0;
                    if (cmd_is_write(status)) begin
                        state_d    = ST_WR_WAIT;
                        bus_we_d   = 1'b1;
                        bus_addr_d = addr;
                        burst_d    = cmd_is_burst(status);
                    end else if (cmd_is_read(status)) begin
                        state_d    = ST_RD_BUS;
                        bus_we_d   = 1'b0;
                        bus_addr_d = addr;
                        burst_d    = cmd_is_burst(status);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (data_ready || cs_n) begin
                    rdata_valid_d = 1'b0;
                end else begin
                    rdata_valid_d = rdata_valid_q;
                end
            end
            ST_WR_WAIT: begin
                if (cs_n) begin
                    state_d       = ST_IDLE;
                    rdata_valid_d = 1'b0;
                end else if (data_ready) begin
                    bus_wdata_d = wdata;
                    state_d     = ST_WR_BUS;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_BUS: begin
                err_d = err_d | data_ready;
                if (bus_ack) begin
                    if (burst_q) begin
                        bus_addr_d = bus_addr_q + 20'd1;
                        state_d    = ST_WR_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (cs_n) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WR_BUS;
                end
            end
            ST_RD_BUS: begin
                if (bus_ack) begin
                    rdata_d       = bus_rdata;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_RD_HOLD;
                end else if (timer_expired) begin
                    // A dead bus still hands the data path a recognisable word.
                    rdata_d       = 16'hFFFF;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                    err_d         = 1'b1;
                end else if (cs_n) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RD_BUS;
                end
            end
            ST_RD_HOLD: begin
                if (cs_n) begin
                    state_d       = ST_IDLE;
                    rdata_valid_d = 1'b0;
                end else if (data_ready) begin
                    rdata_valid_d = 1'b0;
                    if (burst_q) begin
                        bus_addr_d = bus_addr_q + 20'd1;
                        state_d    = ST_RD_BUS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RD_HOLD;
                end
            end
            ST_DRAIN: begin
                if (bus_ack) begin
                    state_d = ST_IDLE;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus_req_d = (state_d == ST_WR_BUS) || (state_d == ST_RD_BUS) || (state_d == ST_DRAIN);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            burst_q       <= 1'b0;
            rdata_q       <= 16'h0000;
            rdata_valid_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 20'h00000;
            bus_wdata_q   <= 16'h0000;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl: a per-cycle vector table followed by
// hand-written burst read, timeout, frame-abort and reset sequences.
module tb_spi_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, cs_n, address_ready, data_ready, bus_ack;
    logic [19:0] addr;
    logic [3:0]  status;
    logic [15:0] wdata, bus_rdata;
    logic [15:0] rdata, bus_wdata;
    logic [19:0] bus_addr;
    logic        rdata_valid, bus_req, bus_we, busy, err;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    spi_bus_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cs_n          (cs_n),
        .address_ready (address_ready),
        .data_ready    (data_ready),
        .addr          (addr),
        .status        (status),
        .wdata         (wdata),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Completed bus accesses, as seen on the bus itself.
    always @(posedge clk) begin
        if (reset_n && bus_req && bus_ack) acc_cnt <= acc_cnt + 1;
    end

    typedef struct {
        logic        rst_n, cs, ar, dr;
        logic [3:0]  st;
        logic [19:0] a;
        logic [15:0] wd;
        logic        ack;
        logic [15:0] brd;
        logic [56:0] exp_o;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [56:0] ex(input logic req, input logic we, input logic [19:0] a,
                                       input logic [15:0] wd, input logic [15:0] rd,
                                       input logic rv, input logic bsy, input logic e);
        return {req, we, a, wd, rd, rv, bsy, e};
    endfunction

    function automatic void add(input logic rst_n, input logic cs, input logic ar, input logic dr,
                                input logic [3:0] st, input logic [19:0] a, input logic [15:0] wd,
                                input logic ack, input logic [15:0] brd, input logic [56:0] e);
        vec_t v;
        v.rst_n = rst_n; v.cs = cs; v.ar = ar; v.dr = dr; v.st = st; v.a = a;
        v.wd = wd; v.ack = ack; v.brd = brd; v.exp_o = e;
        tbl.push_back(v);
    endfunction

    function automatic logic [56:0] outs();
        return {bus_req, bus_we, bus_addr, bus_wdata, rdata, rdata_valid, busy, err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset_n = 1'b1; cs_n = 1'b0; address_ready = 1'b0; data_ready = 1'b0;
        addr = 20'h00000; status = 4'h0; wdata = 16'h0000; bus_ack = 1'b0; bus_rdata = 16'h0000;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        chk(name, {63'd0, bus_req}, 64'd1);
    endtask

    logic [19:0] exp_addr[3];
    logic [15:0] rd_word[3];
    int          n_req;
    int          base;
    logic        seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;

        // rst_n cs ar dr st a wd ack brd | req we addr wdata rdata rv busy err
        add(1'b0,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'h00000,16'h0000,16'h0000,1'b0,1'b0,1'b0));
        add(1'b0,1'b0,1'b1,1'b0,4'h8,20'h00005,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'h00000,16'h0000,16'h0000,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'h00000,16'h0000,16'h0000,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b1,1'b0,4'h5,20'h00123,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'h00000,16'h0000,16'h0000,1'b0,1'b0,1'b1));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'h00000,16'h0000,16'h0000,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b1,1'b0,4'h2,20'h00010,16'h0000,1'b0,16'h0000, ex(1'b0,1'b1,20'h00010,16'h0000,16'h0000,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b1,4'h0,20'h00000,16'hC69A,1'b0,16'h0000, ex(1'b1,1'b1,20'h00010,16'hC69A,16'h0000,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b1,1'b1,20'h00010,16'hC69A,16'h0000,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b1,16'h0000, ex(1'b0,1'b1,20'h00010,16'hC69A,16'h0000,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b1,20'h00010,16'hC69A,16'h0000,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b1,1'b0,4'h8,20'hABCDE,16'h0000,1'b0,16'h0000, ex(1'b1,1'b0,20'hABCDE,16'hC69A,16'h0000,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b1,16'h1234, ex(1'b0,1'b0,20'hABCDE,16'hC69A,16'h1234,1'b1,1'b1,1'b0));
        add(1'b1,1'b0,1'b1,1'b0,4'h2,20'h55555,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'hABCDE,16'hC69A,16'h1234,1'b1,1'b1,1'b1));
        add(1'b1,1'b0,1'b0,1'b1,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'hABCDE,16'hC69A,16'h1234,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b1,1'b0,4'h3,20'hFFFFF,16'h0000,1'b0,16'h0000, ex(1'b0,1'b1,20'hFFFFF,16'hC69A,16'h1234,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b1,4'h0,20'h00000,16'hAAAA,1'b0,16'h0000, ex(1'b1,1'b1,20'hFFFFF,16'hAAAA,16'h1234,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b1,4'h0,20'h00000,16'hBBBB,1'b0,16'h0000, ex(1'b1,1'b1,20'hFFFFF,16'hAAAA,16'h1234,1'b0,1'b1,1'b1));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b1,16'h0000, ex(1'b0,1'b1,20'h00000,16'hAAAA,16'h1234,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b1,4'h0,20'h00000,16'h5555,1'b0,16'h0000, ex(1'b1,1'b1,20'h00000,16'h5555,16'h1234,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b1,16'h0000, ex(1'b0,1'b1,20'h00001,16'h5555,16'h1234,1'b0,1'b1,1'b0));
        add(1'b1,1'b1,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b1,20'h00001,16'h5555,16'h1234,1'b0,1'b0,1'b0));
        add(1'b1,1'b0,1'b1,1'b0,4'h9,20'h00100,16'h0000,1'b0,16'h0000, ex(1'b1,1'b0,20'h00100,16'h5555,16'h1234,1'b0,1'b1,1'b0));
        add(1'b1,1'b0,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b1,16'hBEEF, ex(1'b0,1'b0,20'h00100,16'h5555,16'hBEEF,1'b1,1'b1,1'b0));
        add(1'b1,1'b1,1'b0,1'b0,4'h0,20'h00000,16'h0000,1'b0,16'h0000, ex(1'b0,1'b0,20'h00100,16'h5555,16'hBEEF,1'b0,1'b0,1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset_n = tbl[i].rst_n; cs_n = tbl[i].cs; address_ready = tbl[i].ar;
            data_ready = tbl[i].dr; status = tbl[i].st; addr = tbl[i].a;
            wdata = tbl[i].wd; bus_ack = tbl[i].ack; bus_rdata = tbl[i].brd;
            tick();
            chk($sformatf("vec%0d", i), {7'd0, outs()}, {7'd0, tbl[i].exp_o});
        end
        idle_inputs();

        // Burst read across the 20-bit address wrap.
        exp_addr[0] = 20'hFFFFF; exp_addr[1] = 20'h00000; exp_addr[2] = 20'h00001;
        rd_word[0] = 16'h1111; rd_word[1] = 16'h2222; rd_word[2] = 16'h3333;
        base = acc_cnt;
        address_ready = 1'b1; status = 4'h9; addr = 20'hFFFFF;
        tick();
        address_ready = 1'b0;
        chk("rd_latency", {63'd0, bus_req}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            wait_req($sformatf("burst_req%0d", k));
            chk($sformatf("burst_addr%0d", k), {44'd0, bus_addr}, {44'd0, exp_addr[k]});
            chk($sformatf("burst_we%0d", k), {63'd0, bus_we}, 64'd0);
            bus_ack = 1'b1; bus_rdata = rd_word[k];
            tick();
            bus_ack = 1'b0;
            chk($sformatf("burst_data%0d", k), {46'd0, bus_req, rdata_valid, rdata}, {46'd0, 1'b0, 1'b1, rd_word[k]});
            data_ready = 1'b1;
            cs_n = (k == 2);
            tick();
            data_ready = 1'b0;
            cs_n = 1'b0;
        end
        chk("burst_end", {61'd0, bus_req, rdata_valid, busy}, 64'd0);
        chk("burst_count", 64'(acc_cnt - base), 64'd3);

        // Read with the bus never answering.
        address_ready = 1'b1; status = 4'h8; addr = 20'h00042;
        tick();
        address_ready = 1'b0;
        n_req = 0;
        while (bus_req && n_req < 400) begin
            n_req++;
            tick();
        end
        chk("timeout_len", 64'(n_req), 64'd255);
        chk("timeout_out", {44'd0, err, rdata, rdata_valid, busy, bus_req}, {44'd0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        tick();
        chk("timeout_err_pulse", {63'd0, err}, 64'd0);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("timeout_rv_clear", {63'd0, rdata_valid}, 64'd0);

        // Frame ends while a burst write is on the bus; ack five cycles later.
        base = acc_cnt;
        address_ready = 1'b1; status = 4'h3; addr = 20'h00200;
        tick();
        address_ready = 1'b0;
        data_ready = 1'b1; wdata = 16'h1357;
        tick();
        data_ready = 1'b0;
        chk("drain_access", {26'd0, bus_req, bus_we, bus_addr, bus_wdata}, {26'd0, 1'b1, 1'b1, 20'h00200, 16'h1357});
        cs_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("drain_hold%0d", i), {62'd0, bus_req, busy}, {62'd0, 1'b1, 1'b1});
        end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("drain_done", {62'd0, bus_req, busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | bus_req;
        end
        chk("drain_no_reissue", {63'd0, seen}, 64'd0);
        chk("drain_count", 64'(acc_cnt - base), 64'd1);
        cs_n = 1'b0;

        // Reset in the middle of a read access.
        address_ready = 1'b1; status = 4'h9; addr = 20'h12345;
        tick();
        address_ready = 1'b0;
        chk("pre_reset_req", {63'd0, bus_req}, 64'd1);
        reset_n = 1'b0;
        tick();
        chk("reset_outs", {7'd0, outs()}, 64'd0);
        reset_n = 1'b1;
        tick();
        chk("post_reset_outs", {7'd0, outs()}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
